johnson_seq_ctrl: RTL and testbench

Sequencing controller that owns an N-stage Johnson (twisted-ring) register and steps it through a programmed number of phases on request. A start/done handshake launches and completes each run. Hold and stop inputs give pause and abort control. The block exports the raw ring state, a one-hot decoded phase and status, and is the unit that drives downstream phase-sequenced logic.

---
 rtl/johnson_seq_ctrl_if.sv | 58 +++++
 rtl/johnson_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/johnson_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// johnson_seq_ctrl_if
// Bundle of control and status signals for the Johnson-ring sequencing
// controller.
//
// Optional macro: JSEQ_REVERSE_EN adds the 'dir' direction select.
//
// Signals:
//   start      launch request (only honoured while the controller is idle)
//   steps      number of ring advances for the run (CNT_W bits)
//   hold       pause: no advance and no decrement in that cycle
//   stop       abort the current run
//   dir        (JSEQ_REVERSE_EN only) 0 = forward advance, 1 = reverse
//   q          raw ring state, q[0] is the first stage (N bits)
//   phase      one-hot decode of q (2N bits)
//   remaining  advances still outstanding in the current run
//   busy       run in progress
//   done       one-cycle pulse after the last advance of a run
//   aborted    one-cycle pulse after a stop-terminated run
//
// Modports:
//   master  the sequencing client (drives requests, reads status)
//   slave   the controller itself
// ---------------------------------------------------------------------------
interface johnson_seq_ctrl_if #(
   parameter int N     = 4,
   parameter int CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] steps;
   logic             hold;
   logic             stop;
`ifdef JSEQ_REVERSE_EN
   logic             dir;
`endif
   logic [N-1:0]     q;
   logic [2*N-1:0]   phase;
   logic [CNT_W-1:0] remaining;
   logic             busy;
   logic             done;
   logic             aborted;

   modport master (
      output start, steps, hold, stop,
`ifdef JSEQ_REVERSE_EN
      output dir,
`endif
      input  q, phase, remaining, busy, done, aborted
   );

   modport slave (
      input  start, steps, hold, stop,
`ifdef JSEQ_REVERSE_EN
      input  dir,
`endif
      output q, phase, remaining, busy, done, aborted
   );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_seq_ctrl
// Owns an N-stage Johnson (twisted-ring) register and steps it through a
// programmed number of phases per run. A run is launched by start (with a
// non-zero step count) and finishes with a one-cycle done pulse, or with a
// one-cycle aborted pulse if stop is raised. hold pauses the run.
//
// Optional macro: JSEQ_REVERSE_EN adds bus.dir; when 1 the ring advances in
// the reverse direction. Without the macro only forward advance exists.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   johnson_seq_ctrl_if.slave: start/steps/hold/stop[/dir] in,
//         q/phase/remaining/busy/done/aborted out
// ---------------------------------------------------------------------------
module johnson_seq_ctrl #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   johnson_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      ABORT = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [N-1:0]     q_reg, q_next;
   logic [CNT_W-1:0] remaining_reg, remaining_next;

   logic [N-1:0]     fwd_q;
   logic [N-1:0]     adv_q;
   logic [2*N-1:0]   phase_vec;
   int               phase_k;

   logic             busy_out, done_out, aborted_out;

   // Forward advance: inverted tail fed back into the first stage.
   assign fwd_q[0] = ~q_reg[N-1];
   for (genvar gi = 1; gi < N; gi++) begin : g_fwd
      assign fwd_q[gi] = q_reg[gi-1];
   end

`ifdef JSEQ_REVERSE_EN
   logic [N-1:0] rev_q;

   // Reverse advance: inverted first stage fed back into the tail.
   assign rev_q[N-1] = ~q_reg[0];
   for (genvar gi = 0; gi < N-1; gi++) begin : g_rev
      assign rev_q[gi] = q_reg[gi+1];
   end

   assign adv_q = bus.dir ? rev_q : fwd_q;
`else
   assign adv_q = fwd_q;
`endif

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= IDLE;
         q_reg         <= '0;
         remaining_reg <= '0;
      end else begin
         state_reg     <= state_next;
         q_reg         <= q_next;
         remaining_reg <= remaining_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next     = state_reg;
      q_next         = q_reg;
      remaining_next = remaining_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               q_next         = '0;
               remaining_next = bus.steps;
               // A zero-length run completes immediately without ever
               // showing busy.
               state_next     = (bus.steps == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            // stop wins over both hold and the final advance.
            if (bus.stop) begin
               state_next = ABORT;
            end else if (!bus.hold) begin
               q_next         = adv_q;
               remaining_next = remaining_reg - CNT_W'(1);
               if (remaining_reg == CNT_W'(1)) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            remaining_next = '0;
            state_next     = IDLE;
         end
         ABORT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output logic (status flags are pure state decodes)
   always_comb begin
      busy_out    = 1'b0;
      done_out    = 1'b0;
      aborted_out = 1'b0;
      case (state_reg)
         RUN:     busy_out    = 1'b1;
         DONE:    done_out    = 1'b1;
         ABORT:   aborted_out = 1'b1;
         default: ;
      endcase
   end

   // Phase index: the ring fills with ones from q[0] during the first half
   // of the cycle (index = ones) and drains them from q[0] during the
   // second half (index = 2N - ones).
   always_comb begin
      int ones;
      ones = 0;
      for (int i = 0; i < N; i++) begin
         ones = ones + int'(q_reg[i]);
      end
      if (q_reg[0]) begin
         phase_k = ones;
      end else if (ones == 0) begin
         phase_k = 0;
      end else begin
         phase_k = 2*N - ones;
      end
   end

   for (genvar gi = 0; gi < 2*N; gi++) begin : g_phase
      assign phase_vec[gi] = (phase_k == gi);
   end

   assign bus.q         = q_reg;
   assign bus.phase     = phase_vec;
   assign bus.remaining = remaining_reg;
   assign bus.busy      = busy_out;
   assign bus.done      = done_out;
   assign bus.aborted   = aborted_out;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_johnson_seq_ctrl
// Directed bench for johnson_seq_ctrl with N=4, CNT_W=8. A vector table
// covers a full-wrap run and a run with hold; hand-written sequences cover
// stop, zero-length runs, start while busy, reset mid-run and (with
// JSEQ_REVERSE_EN) reverse stepping. Ring values in the bench are written
// in display order {q[0],q[1],q[2],q[3]}.
// ---------------------------------------------------------------------------
module tb_johnson_seq_ctrl;

   logic clk;
   logic rst;

   johnson_seq_ctrl_if #(.N(4), .CNT_W(8)) bus ();

   johnson_seq_ctrl #(.N(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int start;
      int steps;
      int hold;
      int stop;
      int qd;     // expected q, display order
      int k;      // expected phase index
      int rem;
      int busy;
      int done;
      int aborted;
   } vec_t;

   vec_t vecs[17];

   int total_checks;
   int passed_checks;

   function automatic int disp2q(input int d);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) begin
         if (d[3-i]) r = r | (1 << i);
      end
      return r;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      total_checks++;
      if (got == exp) begin
         passed_checks++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input int qd, input int k,
                                input int rem, input int b, input int d,
                                input int a);
      $display("%s: q(raw)=%b phase=%b rem=%0d busy=%0d done=%0d aborted=%0d",
               tag, bus.q, bus.phase, bus.remaining, bus.busy, bus.done,
               bus.aborted);
      check({tag, ".q"},         int'(bus.q),         disp2q(qd));
      check({tag, ".phase"},     int'(bus.phase),     1 << k);
      check({tag, ".remaining"}, int'(bus.remaining), rem);
      check({tag, ".busy"},      int'(bus.busy),      b);
      check({tag, ".done"},      int'(bus.done),      d);
      check({tag, ".aborted"},   int'(bus.aborted),   a);
   endtask

   task automatic drive(input int st, input int n, input int h, input int sp);
      bus.start = st[0];
      bus.steps = 8'(n);
      bus.hold  = h[0];
      bus.stop  = sp[0];
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;

      //            start steps hold stop qd       k rem busy done ab
      // Full 8-step run: walks all phases and wraps back to 0000.
      vecs[0]  = '{1, 8,  0, 0, 'b0000, 0, 8, 1, 0, 0};
      vecs[1]  = '{0, 8,  0, 0, 'b1000, 1, 7, 1, 0, 0};
      vecs[2]  = '{0, 8,  0, 0, 'b1100, 2, 6, 1, 0, 0};
      vecs[3]  = '{0, 8,  0, 0, 'b1110, 3, 5, 1, 0, 0};
      vecs[4]  = '{0, 8,  0, 0, 'b1111, 4, 4, 1, 0, 0};
      vecs[5]  = '{0, 8,  0, 0, 'b0111, 5, 3, 1, 0, 0};
      vecs[6]  = '{0, 8,  0, 0, 'b0011, 6, 2, 1, 0, 0};
      vecs[7]  = '{0, 8,  0, 0, 'b0001, 7, 1, 1, 0, 0};
      vecs[8]  = '{0, 8,  0, 0, 'b0000, 0, 0, 0, 1, 0};
      vecs[9]  = '{0, 8,  0, 0, 'b0000, 0, 0, 0, 0, 0};
      // 3-step run with hold for two cycles after the first advance.
      vecs[10] = '{1, 3,  0, 0, 'b0000, 0, 3, 1, 0, 0};
      vecs[11] = '{0, 3,  0, 0, 'b1000, 1, 2, 1, 0, 0};
      vecs[12] = '{0, 3,  1, 0, 'b1000, 1, 2, 1, 0, 0};
      vecs[13] = '{0, 3,  1, 0, 'b1000, 1, 2, 1, 0, 0};
      vecs[14] = '{0, 3,  0, 0, 'b1100, 2, 1, 1, 0, 0};
      vecs[15] = '{0, 3,  0, 0, 'b1110, 3, 0, 0, 1, 0};
      vecs[16] = '{0, 3,  0, 0, 'b1110, 3, 0, 0, 0, 0};

      rst = 1'b0;
`ifdef JSEQ_REVERSE_EN
      bus.dir = 1'b0;
`endif
      drive(0, 0, 0, 0);
      step();
      step();
      check_outputs("reset", 'b0000, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      check_outputs("post_reset_idle", 'b0000, 0, 0, 0, 0, 0);

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].start, vecs[i].steps, vecs[i].hold, vecs[i].stop);
         step();
         check_outputs($sformatf("vec%0d", i), vecs[i].qd, vecs[i].k,
                       vecs[i].rem, vecs[i].busy, vecs[i].done,
                       vecs[i].aborted);
      end

      // Stop after 5 advances of a 10-step run (hold also raised: stop wins).
      drive(1, 10, 0, 0);
      step();
      check_outputs("stop_launch", 'b0000, 0, 10, 1, 0, 0);
      drive(0, 10, 0, 0);
      for (int i = 0; i < 5; i++) step();
      check_outputs("stop_5adv", 'b0111, 5, 5, 1, 0, 0);
      drive(0, 10, 1, 1);
      step();
      check_outputs("stop_abort", 'b0111, 5, 5, 0, 0, 1);
      drive(0, 10, 0, 0);
      step();
      check_outputs("stop_idle", 'b0111, 5, 5, 0, 0, 0);

      // Stop on what would be the final advance: abort, no done.
      drive(1, 1, 0, 0);
      step();
      check_outputs("stopfin_launch", 'b0000, 0, 1, 1, 0, 0);
      drive(0, 1, 0, 1);
      step();
      check_outputs("stopfin_abort", 'b0000, 0, 1, 0, 0, 1);
      drive(0, 1, 0, 0);
      step();
      check_outputs("stopfin_idle", 'b0000, 0, 1, 0, 0, 0);

      // start held high while busy is ignored.
      drive(1, 2, 0, 0);
      step();
      check_outputs("busy_launch", 'b0000, 0, 2, 1, 0, 0);
      drive(1, 2, 0, 0);
      step();
      check_outputs("busy_ignored", 'b1000, 1, 1, 1, 0, 0);
      drive(0, 2, 0, 0);
      step();
      check_outputs("busy_done", 'b1100, 2, 0, 0, 1, 0);
      step();
      check_outputs("busy_idle", 'b1100, 2, 0, 0, 0, 0);

      // Zero-length run: clears q, done pulse, busy never rises.
      drive(1, 0, 0, 0);
      step();
      check_outputs("zero_done", 'b0000, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0);
      step();
      check_outputs("zero_idle", 'b0000, 0, 0, 0, 0, 0);

      // Reset mid-run at 1110: no done/aborted pulse afterwards.
      drive(1, 5, 0, 0);
      step();
      drive(0, 5, 0, 0);
      step();
      step();
      step();
      check_outputs("rst_pre", 'b1110, 3, 2, 1, 0, 0);
      rst = 1'b0;
      step();
      check_outputs("rst_mid", 'b0000, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      check_outputs("rst_after1", 'b0000, 0, 0, 0, 0, 0);
      step();
      check_outputs("rst_after2", 'b0000, 0, 0, 0, 0, 0);

`ifdef JSEQ_REVERSE_EN
      // Reverse stepping from 0000.
      bus.dir = 1'b1;
      drive(1, 3, 0, 0);
      step();
      check_outputs("rev_launch", 'b0000, 0, 3, 1, 0, 0);
      drive(0, 3, 0, 0);
      step();
      check_outputs("rev_1", 'b0001, 7, 2, 1, 0, 0);
      step();
      check_outputs("rev_2", 'b0011, 6, 1, 1, 0, 0);
      step();
      check_outputs("rev_3", 'b0111, 5, 0, 0, 1, 0);
      bus.dir = 1'b0;
      step();
      check_outputs("rev_idle", 'b0111, 5, 0, 0, 0, 0);
`endif

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
